// File: rtl/branch_predict_ctrl_if.sv
// ============================================================================
// Module  : branch_predict_ctrl_if
// Brief   : Fetch-lookup / execute-resolve bundle for the branch predictor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predict_ctrl_if #(
    parameter int PC_W  = 13,
    parameter int CNT_W = 32
);
    logic [PC_W-1:0]  f_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_pc;
    logic             e_valid;
    logic [PC_W-1:0]  e_pc;
    logic [1:0]       e_jump_code;
    logic             e_taken;
    logic [PC_W-1:0]  e_nextpc;
    logic             e_fail_predict;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output f_pc, e_valid, e_pc, e_jump_code, e_taken, e_nextpc, e_fail_predict,
        input  pred_taken, pred_pc, flush, redirect_pc, br_count, miss_count
    );

    modport slave (
        input  f_pc, e_valid, e_pc, e_jump_code, e_taken, e_nextpc, e_fail_predict,
        output pred_taken, pred_pc, flush, redirect_pc, br_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
// ============================================================================
// Module  : branch_predict_ctrl
// Brief   : Direct-mapped BTB with 2-bit counters plus mispredict redirect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_ctrl #(
    parameter int PC_W  = 13,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    branch_predict_ctrl_if.slave bus
);
    localparam int c_entries = 1 << IDX_W;
    localparam int c_tag_w   = PC_W - IDX_W;

    logic               r_valid  [c_entries];
    logic [c_tag_w-1:0] r_tag    [c_entries];
    logic [PC_W-1:0]    r_target [c_entries];
    logic [1:0]         r_ctr    [c_entries];

    logic               r_flush;
    logic [PC_W-1:0]    r_redirect_pc;
    logic [CNT_W-1:0]   r_br_count;
    logic [CNT_W-1:0]   r_miss_count;

    logic [IDX_W-1:0]   w_f_idx;
    logic [c_tag_w-1:0] w_f_tag;
    logic               w_f_hit;
    logic [IDX_W-1:0]   w_e_idx;
    logic [c_tag_w-1:0] w_e_tag;
    logic               w_e_hit;
    logic               w_accept;

    // Fetch-side lookup sees only pre-edge table state.
    assign w_f_idx        = bus.f_pc[IDX_W-1:0];
    assign w_f_tag        = bus.f_pc[PC_W-1:IDX_W];
    assign w_f_hit        = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign bus.pred_taken = w_f_hit && r_ctr[w_f_idx][1];
    assign bus.pred_pc    = bus.pred_taken ? r_target[w_f_idx] : (bus.f_pc + PC_W'(1));

    assign w_e_idx  = bus.e_pc[IDX_W-1:0];
    assign w_e_tag  = bus.e_pc[PC_W-1:IDX_W];
    assign w_e_hit  = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    // The instruction in E during a flush cycle is wrong-path.
    assign w_accept = bus.e_valid && !r_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_entries; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_accept) begin
            case (bus.e_jump_code)
                2'b01: begin
                    if (w_e_hit) begin
                        if (bus.e_taken) begin
                            if (r_ctr[w_e_idx] != 2'b11) r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'd1;
                            r_target[w_e_idx] <= bus.e_nextpc;
                        end else if (r_ctr[w_e_idx] != 2'b00) begin
                            r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'd1;
                        end
                    end else if (bus.e_taken) begin
                        r_valid[w_e_idx]  <= 1'b1;
                        r_tag[w_e_idx]    <= w_e_tag;
                        r_target[w_e_idx] <= bus.e_nextpc;
                        r_ctr[w_e_idx]    <= 2'b10;
                    end
                end
                2'b10: begin
                    r_valid[w_e_idx]  <= 1'b1;
                    r_tag[w_e_idx]    <= w_e_tag;
                    r_target[w_e_idx] <= bus.e_nextpc;
                    r_ctr[w_e_idx]    <= 2'b11;
                end
                2'b11: begin
                    if (w_e_hit) r_valid[w_e_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_br_count    <= '0;
            r_miss_count  <= '0;
        end else begin
            r_flush <= w_accept && bus.e_fail_predict;
            if (w_accept && bus.e_fail_predict) r_redirect_pc <= bus.e_nextpc;
            if (w_accept && (bus.e_jump_code != 2'b00) && (r_br_count != '1))
                r_br_count <= r_br_count + CNT_W'(1);
            if (w_accept && bus.e_fail_predict && (r_miss_count != '1))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    assign bus.flush       = r_flush;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.br_count    = r_br_count;
    assign bus.miss_count  = r_miss_count;
endmodule

`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
// ============================================================================
// Module  : tb_branch_predict_ctrl
// Brief   : Directed self-checking bench; narrow counters make saturation reachable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_ctrl;
    localparam int PC_W  = 13;
    localparam int IDX_W = 6;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    branch_predict_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_predict_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_drive(input logic [1:0] code, input logic [12:0] pc, input logic taken,
                           input logic [12:0] nextpc, input logic fail);
        bus.e_valid        = 1'b1;
        bus.e_jump_code    = code;
        bus.e_pc           = pc;
        bus.e_taken        = taken;
        bus.e_nextpc       = nextpc;
        bus.e_fail_predict = fail;
    endtask

    task automatic e_op(input logic [1:0] code, input logic [12:0] pc, input logic taken,
                        input logic [12:0] nextpc, input logic fail);
        e_drive(code, pc, taken, nextpc, fail);
        tick();
        bus.e_valid = 1'b0;
    endtask

    task automatic look(input logic [12:0] pc, input string nm,
                        input logic exp_t, input logic [12:0] exp_pc);
        bus.f_pc = pc;
        #1;
        compared++;
        if (bus.pred_taken !== exp_t || bus.pred_pc !== exp_pc) begin
            mismatched++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h",
                     nm, bus.pred_taken, bus.pred_pc, exp_t, exp_pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.f_pc = '0; bus.e_valid = 1'b0; bus.e_pc = '0; bus.e_jump_code = 2'b00;
        bus.e_taken = 1'b0; bus.e_nextpc = '0; bus.e_fail_predict = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (bus.flush !== 1'b0 || bus.redirect_pc !== 13'h0 || bus.br_count !== 4'd0
            || bus.miss_count !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_state: got flush=%0b rpc=%h br=%0d miss=%0d, want 0/0/0/0",
                     bus.flush, bus.redirect_pc, bus.br_count, bus.miss_count);
        end
        look(13'h0040, "reset_lookup_0040", 1'b0, 13'h0041);
        look(13'h1FFF, "reset_lookup_wrap", 1'b0, 13'h0000);
    endtask

    task automatic test_alloc_redirect();
        e_drive(2'b01, 13'h0040, 1'b1, 13'h0010, 1'b1);
        tick();
        compared++;
        if (bus.flush !== 1'b1 || bus.redirect_pc !== 13'h0010) begin
            mismatched++;
            $display("FAIL alloc_flush: got flush=%0b rpc=%h, want 1/0010", bus.flush, bus.redirect_pc);
        end
        // Wrong-path jal during the flush cycle must be dropped entirely.
        e_drive(2'b10, 13'h0080, 1'b1, 13'h0300, 1'b1);
        tick();
        bus.e_valid = 1'b0;
        compared++;
        if (bus.flush !== 1'b0 || bus.redirect_pc !== 13'h0010 || bus.br_count !== 4'd1
            || bus.miss_count !== 4'd1) begin
            mismatched++;
            $display("FAIL flush_cycle_squash: got flush=%0b rpc=%h br=%0d miss=%0d, want 0/0010/1/1",
                     bus.flush, bus.redirect_pc, bus.br_count, bus.miss_count);
        end
        look(13'h0040, "alloc_predict", 1'b1, 13'h0010);
        look(13'h0080, "squashed_jal_absent", 1'b0, 13'h0081);
    endtask

    task automatic test_counter();
        e_op(2'b01, 13'h0040, 1'b0, 13'h0041, 1'b0);
        e_op(2'b01, 13'h0040, 1'b0, 13'h0041, 1'b0);
        e_op(2'b01, 13'h0040, 1'b1, 13'h0010, 1'b0);
        look(13'h0040, "ctr_00_to_01", 1'b0, 13'h0041);
        e_op(2'b01, 13'h0040, 1'b1, 13'h0020, 1'b0);
        look(13'h0040, "ctr_01_to_10_newtgt", 1'b1, 13'h0020);
        for (int i = 0; i < 5; i++) e_op(2'b01, 13'h0040, 1'b1, 13'h0020, 1'b0);
        e_op(2'b01, 13'h0040, 1'b0, 13'h0041, 1'b0);
        look(13'h0040, "ctr_sat11_then_nt", 1'b1, 13'h0020);
        e_op(2'b01, 13'h0040, 1'b0, 13'h0041, 1'b0);
        look(13'h0040, "ctr_10_to_01", 1'b0, 13'h0041);
        compared++;
        if (bus.br_count !== 4'd12 || bus.miss_count !== 4'd1 || bus.flush !== 1'b0) begin
            mismatched++;
            $display("FAIL counter_stats: got br=%0d miss=%0d flush=%0b, want 12/1/0",
                     bus.br_count, bus.miss_count, bus.flush);
        end
    endtask

    task automatic test_alias();
        e_op(2'b10, 13'h0040, 1'b1, 13'h0100, 1'b0);
        look(13'h0040, "jal_alloc", 1'b1, 13'h0100);
        e_op(2'b01, 13'h1040, 1'b1, 13'h0200, 1'b0);
        look(13'h0040, "alias_evicted", 1'b0, 13'h0041);
        look(13'h1040, "alias_new", 1'b1, 13'h0200);
    endtask

    task automatic test_jalr();
        e_op(2'b10, 13'h0040, 1'b1, 13'h0100, 1'b0);
        e_drive(2'b11, 13'h0040, 1'b1, 13'h0555, 1'b0);
        look(13'h0040, "jalr_same_cycle_old", 1'b1, 13'h0100);
        tick();
        bus.e_valid = 1'b0;
        look(13'h0040, "jalr_invalidated", 1'b0, 13'h0041);
        e_op(2'b11, 13'h0080, 1'b1, 13'h0666, 1'b0);
        look(13'h0080, "jalr_no_alloc", 1'b0, 13'h0081);
        e_op(2'b10, 13'h00C0, 1'b1, 13'h0777, 1'b0);
        compared++;
        if (bus.br_count !== 4'hF) begin
            mismatched++;
            $display("FAIL br_saturate: got %0d, want 15", bus.br_count);
        end
    endtask

    task automatic test_nojump_fail();
        e_op(2'b00, 13'h0100, 1'b0, 13'h1234, 1'b1);
        compared++;
        if (bus.flush !== 1'b1 || bus.redirect_pc !== 13'h1234 || bus.br_count !== 4'hF
            || bus.miss_count !== 4'd2) begin
            mismatched++;
            $display("FAIL nojump_fail: got flush=%0b rpc=%h br=%0d miss=%0d, want 1/1234/15/2",
                     bus.flush, bus.redirect_pc, bus.br_count, bus.miss_count);
        end
        tick();
        for (int i = 0; i < 14; i++) begin
            e_op(2'b00, 13'h0100, 1'b0, 13'h0AAA, 1'b1);
            tick();
        end
        compared++;
        if (bus.miss_count !== 4'hF || bus.flush !== 1'b0) begin
            mismatched++;
            $display("FAIL miss_saturate: got miss=%0d flush=%0b, want 15/0", bus.miss_count, bus.flush);
        end
    endtask

    task automatic test_reset_mid_flush();
        e_op(2'b01, 13'h0100, 1'b1, 13'h0BBB, 1'b1);
        compared++;
        if (bus.flush !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_flush: got %0b, want 1", bus.flush);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.flush !== 1'b0 || bus.redirect_pc !== 13'h0 || bus.br_count !== 4'd0
            || bus.miss_count !== 4'd0) begin
            mismatched++;
            $display("FAIL async_reset: got flush=%0b rpc=%h br=%0d miss=%0d, want 0/0/0/0",
                     bus.flush, bus.redirect_pc, bus.br_count, bus.miss_count);
        end
        look(13'h1040, "reset_clears_table", 1'b0, 13'h1041);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_alloc_redirect();
        test_counter();
        test_alias();
        test_jalr();
        test_nojump_fail();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Branch prediction and redirect controller for the 13-bit word-addressed PC pipeline. F stage looks it up combinationally to produce the predicted next PC. E stage feeds it the resolved branch outcome, which trains a direct-mapped BTB with 2-bit saturating counters. On a misprediction it issues a registered one-cycle flush/redirect and squashes the wrong-path update that follows.

Parameters:
PC_W, 13, PC width in words
IDX_W, 6, index bits (2^IDX_W entries); tag = f_pc[PC_W-1:IDX_W], TAG_W = PC_W-IDX_W
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
f_pc  in  PC_W  PC being fetched
pred_taken  out  1  prediction taken (combinational)
pred_pc  out  PC_W  predicted next PC (combinational)
e_valid  in  1  E stage holds a real instruction
e_pc  in  PC_W  PC of E-stage instruction
e_jump_code  in  2  00 none, 01 conditional branch, 10 jal, 11 jalr
e_taken  in  1  resolved taken (jal/jalr always 1)
e_nextpc  in  PC_W  resolved next PC
e_fail_predict  in  1  E-stage mispredict flag
flush  out  1  squash F/D/E, one cycle
redirect_pc  out  PC_W  fetch PC valid while flush=1
br_count  out  CNT_W  accepted branches/jumps
miss_count  out  CNT_W  accepted mispredicts

Behaviour:
- Reset (async, rst_n=0): all entry valid bits=0, counters=2'b01, tags/targets=0; flush=0, redirect_pc=0, br_count=0, miss_count=0. Reset mid-flush drops the flush immediately.
- Entry = {valid, tag[TAG_W], target[PC_W], ctr[2]}.
- Lookup, combinational from current state: hit = valid & tag match at index f_pc[IDX_W-1:0].
  - pred_taken = hit & ctr[1].
  - pred_pc = target if pred_taken, else f_pc+1 modulo 2^PC_W (0x1FFF wraps to 0x0000).
- Accept = e_valid & ~flush. In the flush cycle the E-stage instruction is wrong-path: no table update, no counting, no new flush.
- Update on accept, by e_jump_code (index/tag taken from e_pc):
  - 00: no table change.
  - 01, hit: ctr += 1 if e_taken, else ctr -= 1, saturating at 00/11. target = e_nextpc when e_taken, otherwise unchanged.
  - 01, miss: if e_taken, allocate (replace) with valid=1, ctr=2'b10, target=e_nextpc; if not taken, no change.
  - 10 (jal): hit or miss, write valid=1, ctr=2'b11, target=e_nextpc.
  - 11 (jalr): never allocated; a hitting entry is invalidated (valid=0).
- Same-cycle lookup and update of one entry: lookup returns the pre-edge value; the new value is visible next cycle.
- Redirect: if accept & e_fail_predict at edge N, then in cycle N+1 flush=1 and redirect_pc=e_nextpc (latched). Otherwise flush=0 and redirect_pc holds its last value. Flush is never longer than one cycle, since the flush cycle blocks accept.
- Statistics: br_count += 1 on accept with e_jump_code!=0; miss_count += 1 on accept & e_fail_predict. Both saturate at all-ones and do not wrap.
- Fail flag is taken as given; the block does not recompute it. A fail on e_jump_code=00 still redirects and counts miss only.

Test Plan:
- Reset then f_pc=0x0040 -> pred_taken=0, pred_pc=0x0041; f_pc=0x1FFF -> pred_pc=0x0000; flush=0, both counters 0.
- Branch e_pc=0x0040, e_jump_code=01, e_taken=1, e_nextpc=0x0010, e_fail_predict=1 -> next cycle flush=1, redirect_pc=0x0010. The e_valid in that cycle is ignored. Then f_pc=0x0040 -> pred_taken=1, pred_pc=0x0010; br_count=1, miss_count=1.
- Same branch not taken twice (ctr 10->01->00), then taken once -> ctr 01, pred_taken=0, pred_pc=0x0041; taken again -> pred_taken=1; five taken -> ctr stays 11.
- Aliasing: jal at 0x0040->0x0100, then taken branch at 0x1040 (same index, tag differs) ->0x0200 -> f_pc=0x0040 misses (pred_pc=0x0041), f_pc=0x1040 predicts 0x0200.
- jalr at 0x0040 after jal allocation -> entry invalidated, f_pc=0x0040 gives pred_taken=0; update at same edge as lookup of 0x0040 -> lookup shows old entry that cycle.
- Preload: force br_count=all-ones -> further branches leave it at all-ones. Assert rst_n=0 during flush=1 -> flush and redirect_pc go 0 without a clock edge.
